// File: rtl/mem_request_arbiter_pkg.sv
// Shared types for the memory request arbiter: FSM states, arbitration modes
// and the index-width helper used for requester pointers.
package mem_req_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    HALTED = 2'd2
  } arb_state_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_request_arbiter_if.sv
// Requester-side and memory-side bus bundle. The arbiter uses the master view;
// requesters and the memory controller model use the slave view.
interface mem_request_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_ren;
  logic [NREQ-1:0]    req_wen;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_hit;
  logic [DW-1:0]      req_rdata;
  logic               mem_ren;
  logic               mem_wen;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_hit;
  logic [DW-1:0]      mem_rdata;

  modport master (
    input  req_ren, req_wen, req_addr, req_wdata, mem_hit, mem_rdata,
    output req_hit, req_rdata, mem_ren, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    output req_ren, req_wen, req_addr, req_wdata, mem_hit, mem_rdata,
    input  req_hit, req_rdata, mem_ren, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_request_arbiter_rr_arbiter.sv
// Combinational winner select: round-robin from a pointer, or lowest index first.
module rr_arbiter
  import mem_req_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int ARB_MODE = ARB_RR,
  localparam int IW      = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] pending,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int cand;

  // Scan offsets from the far end so the smallest offset from the pointer wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = (ARB_MODE == ARB_FIXED) ? k : ((int'(ptr) + k) % NREQ);
      if (pending[IW'(cand)]) begin
        idx = IW'(cand);
        any = 1'b1;
      end else begin
        any = any;
      end
    end
    grant[idx] = any;
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Arbitrates NREQ level-held requesters onto one memory port, holding each
// grant until mem_hit or watchdog expiry; halt drains into a terminal state.
module mem_request_arbiter
  import mem_req_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int ARB_MODE = ARB_RR,
  parameter int TIMEOUT  = 255
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   halt,
  mem_request_arbiter_if.master  bus,
  output logic                   busy,
  output logic                   halted,
  output logic                   timeout_err
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          ren_q, ren_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] win_grant;
  logic [IW-1:0]   win_idx;
  logic            win_any;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;
  logic [IW-1:0]   next_ptr;
  logic            done;
  logic            in_grant;

  assign pending  = bus.req_ren | bus.req_wen;
  assign next_ptr = (sel_q == IW'(NREQ - 1)) ? '0 : sel_q + IW'(1);
  assign in_grant = (state_q == GRANT);

  rr_arbiter #(
    .NREQ     (NREQ),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .pending (pending),
    .ptr     (ptr_q),
    .grant   (win_grant),
    .idx     (win_idx),
    .any     (win_any)
  );

  // Route the winner's address and write data toward the latch.
  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_addr  = bus.req_addr[i*AW +: AW];
        win_wdata = bus.req_wdata[i*DW +: DW];
      end else begin
        win_addr  = win_addr;
      end
    end
  end

  // Next-state, latch and watchdog logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = HALTED;
        end else if (win_any) begin
          sel_d   = win_idx;
          wen_d   = |(win_grant & bus.req_wen);
          ren_d   = ~wen_d & (|(win_grant & bus.req_ren));
          addr_d  = win_addr;
          wdata_d = win_wdata;
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // A hit on the expiring cycle is a normal completion.
        if (bus.mem_hit) begin
          done = 1'b1;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          done  = 1'b1;
          err_d = 1'b1;
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
        if (done) begin
          cnt_d   = '0;
          state_d = halt ? HALTED : IDLE;
          ptr_d   = (ARB_MODE == ARB_RR) ? next_ptr : ptr_q;
        end else begin
          state_d = GRANT;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Memory side is quiet outside GRANT; hit is steered to the latched owner.
  always_comb begin
    bus.mem_ren   = in_grant & ren_q;
    bus.mem_wen   = in_grant & wen_q;
    bus.mem_addr  = in_grant ? addr_q : '0;
    bus.mem_wdata = in_grant ? wdata_q : '0;
    bus.req_rdata = bus.mem_rdata;
    bus.req_hit   = '0;
    bus.req_hit[sel_q] = in_grant & bus.mem_hit;
  end

  assign busy        = in_grant;
  assign halted      = (state_q == HALTED);
  assign timeout_err = err_q;

endmodule
